// File: rtl/arp_ctrl.sv
// ARP resolution controller: single-entry IP->MAC cache, request/retry FSM,
// and a two-source arbiter for the shared ARP transmit port.
module arp_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 125000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] local_ip_addr,
  input  logic [31:0] dest_ip_addr,
  input  logic        tx_req,
  output logic        tx_grant,
  output logic        tx_fail,
  output logic [47:0] dest_mac_addr,
  input  logic        arp_found,
  input  logic [31:0] arp_rec_source_ip_addr,
  input  logic [47:0] arp_rec_source_mac_addr,
  input  logic        arp_reply_req,
  output logic        arp_reply_ack,
  output logic        arp_tx_req,
  output logic        arp_tx_type,
  output logic [31:0] arp_tx_target_ip,
  input  logic        arp_tx_ack
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned ATT_W = 4;

  typedef enum logic [2:0] {
    IDLE, CHECK, ARP_SEND, ARP_WAIT, GRANT, FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        target_ip_q, target_ip_d;
  logic               cache_valid_q, cache_valid_d;
  logic [31:0]        cache_ip_q, cache_ip_d;
  logic [47:0]        cache_mac_q, cache_mac_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [ATT_W-1:0]   attempt_q, attempt_d;
  logic [47:0]        dest_mac_q, dest_mac_d;
  logic               tx_grant_q, tx_grant_d;
  logic               tx_fail_q, tx_fail_d;
  logic               tx_req_q, tx_req_d;
  logic               tx_type_q, tx_type_d;
  logic [31:0]        tx_ip_q, tx_ip_d;
  logic               reply_ack_q, reply_ack_d;
  logic               cool_q, cool_d;

  logic               fsm_ack;
  logic               found_match;
  logic               timeout;
  logic               unused_local_ip;

  // The own IP is not needed for resolution; receivers filter on it.
  assign unused_local_ip = ^local_ip_addr;

  assign fsm_ack     = (state_q == ARP_SEND) && tx_req_q && !tx_type_q && arp_tx_ack;
  assign found_match = arp_found && (arp_rec_source_ip_addr == target_ip_q);
  assign timeout     = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Resolution FSM: next state, cache updates and result pulses.
  always_comb begin
    state_d       = state_q;
    target_ip_d   = target_ip_q;
    cache_valid_d = cache_valid_q;
    cache_ip_d    = cache_ip_q;
    cache_mac_d   = cache_mac_q;
    tmo_cnt_d     = tmo_cnt_q;
    attempt_d     = attempt_q;
    dest_mac_d    = dest_mac_q;
    tx_grant_d    = 1'b0;
    tx_fail_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_req) begin
          target_ip_d = dest_ip_addr;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (cache_valid_q && (cache_ip_q == target_ip_q)) begin
          dest_mac_d = cache_mac_q;
          tx_grant_d = 1'b1;
          state_d    = GRANT;
        end else begin
          attempt_d = '0;
          state_d   = ARP_SEND;
        end
      end
      ARP_SEND: begin
        if (fsm_ack) begin
          tmo_cnt_d = '0;
          state_d   = ARP_WAIT;
        end
      end
      ARP_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        // A matching reply takes precedence over a coincident timeout.
        if (found_match) begin
          cache_valid_d = 1'b1;
          cache_ip_d    = target_ip_q;
          cache_mac_d   = arp_rec_source_mac_addr;
          dest_mac_d    = arp_rec_source_mac_addr;
          tx_grant_d    = 1'b1;
          state_d       = GRANT;
        end else if (timeout) begin
          attempt_d = attempt_q + ATT_W'(1);
          if (attempt_d == ATT_W'(MAX_RETRY)) begin
            tx_fail_d = 1'b1;
            state_d   = FAIL;
          end else begin
            state_d = ARP_SEND;
          end
        end
      end
      GRANT:   state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // TX port arbiter: replies win when idle; grant held until ack, then one
  // dead cycle so a just-acked reply source cannot be re-granted.
  always_comb begin
    tx_req_d    = tx_req_q;
    tx_type_d   = tx_type_q;
    tx_ip_d     = tx_ip_q;
    reply_ack_d = 1'b0;
    cool_d      = 1'b0;
    if (tx_req_q) begin
      if (arp_tx_ack) begin
        tx_req_d    = 1'b0;
        cool_d      = 1'b1;
        reply_ack_d = tx_type_q;
      end
    end else if (!cool_q) begin
      if (arp_reply_req) begin
        tx_req_d  = 1'b1;
        tx_type_d = 1'b1;
      end else if (state_q == ARP_SEND) begin
        tx_req_d  = 1'b1;
        tx_type_d = 1'b0;
        tx_ip_d   = target_ip_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      target_ip_q   <= '0;
      cache_valid_q <= 1'b0;
      cache_ip_q    <= '0;
      cache_mac_q   <= '0;
      tmo_cnt_q     <= '0;
      attempt_q     <= '0;
      dest_mac_q    <= '0;
      tx_grant_q    <= 1'b0;
      tx_fail_q     <= 1'b0;
      tx_req_q      <= 1'b0;
      tx_type_q     <= 1'b0;
      tx_ip_q       <= '0;
      reply_ack_q   <= 1'b0;
      cool_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_ip_q   <= target_ip_d;
      cache_valid_q <= cache_valid_d;
      cache_ip_q    <= cache_ip_d;
      cache_mac_q   <= cache_mac_d;
      tmo_cnt_q     <= tmo_cnt_d;
      attempt_q     <= attempt_d;
      dest_mac_q    <= dest_mac_d;
      tx_grant_q    <= tx_grant_d;
      tx_fail_q     <= tx_fail_d;
      tx_req_q      <= tx_req_d;
      tx_type_q     <= tx_type_d;
      tx_ip_q       <= tx_ip_d;
      reply_ack_q   <= reply_ack_d;
      cool_q        <= cool_d;
    end
  end

  assign tx_grant         = tx_grant_q;
  assign tx_fail          = tx_fail_q;
  assign dest_mac_addr    = dest_mac_q;
  assign arp_reply_ack    = reply_ack_q;
  assign arp_tx_req       = tx_req_q;
  assign arp_tx_type      = tx_type_q;
  assign arp_tx_target_ip = tx_ip_q;

endmodule

// File: tb/tb_arp_ctrl.sv
// Self-checking bench for arp_ctrl: scoreboard of expected grant/fail results
// plus directed checks of arbiter timing, retries and reset.
module tb_arp_ctrl;

  localparam int unsigned TMO = 16;
  localparam int unsigned RETRY = 3;

  localparam logic [31:0] IP2 = 32'hC0A8_0002;
  localparam logic [31:0] IP5 = 32'hC0A8_0005;
  localparam logic [31:0] IP7 = 32'hC0A8_0007;
  localparam logic [31:0] IP9 = 32'hC0A8_0009;
  localparam logic [47:0] MAC2 = 48'h000A_3501_0203;
  localparam logic [47:0] MAC5 = 48'h0211_2233_4455;
  localparam logic [47:0] MAC9 = 48'h0299_8877_6655;

  typedef struct packed {
    logic        fail;
    logic [47:0] mac;
  } result_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] local_ip_addr;
  logic [31:0] dest_ip_addr;
  logic        tx_req;
  logic        tx_grant;
  logic        tx_fail;
  logic [47:0] dest_mac_addr;
  logic        arp_found;
  logic [31:0] arp_rec_source_ip_addr;
  logic [47:0] arp_rec_source_mac_addr;
  logic        arp_reply_req;
  logic        arp_reply_ack;
  logic        arp_tx_req;
  logic        arp_tx_type;
  logic [31:0] arp_tx_target_ip;
  logic        arp_tx_ack;

  int errors = 0;
  int checks = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  result_t sb_q[$];

  arp_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(RETRY)) dut (
    .clk(clk), .rst(rst),
    .local_ip_addr(local_ip_addr), .dest_ip_addr(dest_ip_addr),
    .tx_req(tx_req), .tx_grant(tx_grant), .tx_fail(tx_fail),
    .dest_mac_addr(dest_mac_addr),
    .arp_found(arp_found), .arp_rec_source_ip_addr(arp_rec_source_ip_addr),
    .arp_rec_source_mac_addr(arp_rec_source_mac_addr),
    .arp_reply_req(arp_reply_req), .arp_reply_ack(arp_reply_ack),
    .arp_tx_req(arp_tx_req), .arp_tx_type(arp_tx_type),
    .arp_tx_target_ip(arp_tx_target_ip), .arp_tx_ack(arp_tx_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result scoreboard and request-edge counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (arp_tx_req && !req_prev) req_rises++;
      req_prev = arp_tx_req;
      if (tx_grant || tx_fail) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", {62'd0, tx_fail, tx_grant}, 64'd0);
        end else begin
          result_t e;
          e = sb_q.pop_front();
          check("sb_kind", {62'd0, tx_fail, tx_grant}, {62'd0, e.fail, ~e.fail});
          check("sb_mac", 64'(dest_mac_addr), 64'(e.mac));
        end
      end
    end else begin
      req_prev = 1'b0;
    end
  end

  task automatic wait_req(output int n);
    n = 0;
    while (!arp_tx_req && n < 100) begin tick(); n++; end
    check("req_seen", 64'(arp_tx_req), 64'd1);
  endtask

  task automatic serve_tx(input logic exp_type, input logic [31:0] exp_ip);
    int n;
    wait_req(n);
    check("tx_type", 64'(arp_tx_type), 64'(exp_type));
    if (!exp_type) check("tx_ip", 64'(arp_tx_target_ip), 64'(exp_ip));
    arp_tx_ack = 1'b1;
    tick();
    arp_tx_ack = 1'b0;
    check("req_drop", 64'(arp_tx_req), 64'd0);
  endtask

  task automatic request(input logic [31:0] ip);
    dest_ip_addr = ip;
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
  endtask

  task automatic found(input logic [31:0] ip, input logic [47:0] mac);
    arp_found = 1'b1;
    arp_rec_source_ip_addr = ip;
    arp_rec_source_mac_addr = mac;
    tick();
    arp_found = 1'b0;
  endtask

  task automatic hit_check(input logic [31:0] ip, input logic [47:0] mac);
    int rises0;
    rises0 = req_rises;
    sb_q.push_back('{fail: 1'b0, mac: mac});
    request(ip);
    check("hit_early", 64'(tx_grant), 64'd0);
    tick();
    check("hit_grant", 64'(tx_grant), 64'd1);
    check("hit_mac", 64'(dest_mac_addr), 64'(mac));
    tick();
    check("hit_pulse", 64'(tx_grant), 64'd0);
    check("hit_no_arp", 64'(req_rises), 64'(rises0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    local_ip_addr = 32'hC0A8_0001;
    dest_ip_addr = '0;
    tx_req = 1'b0;
    arp_found = 1'b0;
    arp_rec_source_ip_addr = '0;
    arp_rec_source_mac_addr = '0;
    arp_reply_req = 1'b0;
    arp_tx_ack = 1'b0;
    repeat (2) tick();
    check("rst_outs", {59'd0, tx_grant, tx_fail, arp_reply_ack, arp_tx_req, arp_tx_type}, 64'd0);
    check("rst_mac", 64'(dest_mac_addr), 64'd0);
    rst = 1'b0;
    tick();

    // Miss then resolve.
    sb_q.push_back('{fail: 1'b0, mac: MAC2});
    request(IP2);
    serve_tx(1'b0, IP2);
    repeat (4) tick();
    found(IP2, MAC2);
    check("res_grant", 64'(tx_grant), 64'd1);
    check("res_mac", 64'(dest_mac_addr), 64'(MAC2));
    tick();
    check("res_pulse", 64'(tx_grant), 64'd0);

    hit_check(IP2, MAC2);

    // Exhaustion: no reply ever arrives.
    sb_q.push_back('{fail: 1'b1, mac: MAC2});
    request(IP7);
    for (int i = 0; i < 3; i++) begin
      serve_tx(1'b0, IP7);
      n = 0;
      while (!arp_tx_req && !tx_fail && n < 100) begin tick(); n++; end
      if (i < 2) begin
        check("retry_gap", 64'(n), 64'd17);
        check("retry_req", 64'(arp_tx_req), 64'd1);
      end else begin
        check("fail_gap", 64'(n), 64'd16);
        check("fail_pulse", 64'(tx_fail), 64'd1);
      end
    end
    tick();
    check("fail_once", 64'(tx_fail), 64'd0);
    check("fail_no_req", 64'(arp_tx_req), 64'd0);
    tick();
    hit_check(IP2, MAC2);

    // Contention: reply and FSM request both pending.
    request(IP5);
    tick();
    arp_reply_req = 1'b1;
    tick();
    check("cont_first", {62'd0, arp_tx_req, arp_tx_type}, 64'd3);
    arp_tx_ack = 1'b1;
    tick();
    arp_tx_ack = 1'b0;
    check("cont_rack", 64'(arp_reply_ack), 64'd1);
    check("cont_drop", 64'(arp_tx_req), 64'd0);
    arp_reply_req = 1'b0;
    tick();
    check("cont_rack_pulse", 64'(arp_reply_ack), 64'd0);
    check("cont_gap", 64'(arp_tx_req), 64'd0);
    tick();
    check("cont_second", {62'd0, arp_tx_req, arp_tx_type}, 64'd2);
    check("cont_ip", 64'(arp_tx_target_ip), 64'(IP5));
    arp_tx_ack = 1'b1;
    tick();
    arp_tx_ack = 1'b0;

    // Wrong responder, then a match on the timeout cycle.
    repeat (2) tick();
    found(IP9, MAC9);
    check("wrong_ignored", 64'(tx_grant), 64'd0);
    repeat (12) tick();
    sb_q.push_back('{fail: 1'b0, mac: MAC5});
    found(IP5, MAC5);
    check("simul_grant", 64'(tx_grant), 64'd1);
    check("simul_mac", 64'(dest_mac_addr), 64'(MAC5));
    repeat (3) tick();
    check("simul_no_resend", 64'(arp_tx_req), 64'd0);

    // Reset in ARP_WAIT with a reply grant on the port.
    request(IP9);
    serve_tx(1'b0, IP9);
    arp_reply_req = 1'b1;
    repeat (2) tick();
    check("pre_rst_req", 64'(arp_tx_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_outs", {59'd0, tx_grant, tx_fail, arp_reply_ack, arp_tx_req, arp_tx_type}, 64'd0);
    check("arst_mac", 64'(dest_mac_addr), 64'd0);
    check("arst_ip", 64'(arp_tx_target_ip), 64'd0);
    arp_reply_req = 1'b0;
    arp_tx_ack = 1'b1;
    tick();
    arp_tx_ack = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_rack", 64'(arp_reply_ack), 64'd0);
    sb_q.push_back('{fail: 1'b0, mac: MAC2});
    request(IP2);
    serve_tx(1'b0, IP2);
    found(IP2, MAC2);
    check("fresh_grant", 64'(tx_grant), 64'd1);
    repeat (2) tick();

    check("sb_left", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
